tile_flash_drawer: RTL

Downstream consumer of the tile lookup stage (tile origin x/y plus colour). On a start pulse it rasterises one TILE_SIZE x TILE_SIZE tile into the VGA adapter, one pixel per clock. It then holds the lit tile for HOLD_CYCLES, erases it with ERASE_COLOUR, and pulses done. The sequence controller uses done to advance its step counter to the next tile.

---
 rtl/tile_flash_drawer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tile_flash_drawer.sv
// Tile flash drawer: rasterises one TILE_SIZE x TILE_SIZE tile into the VGA
// adapter, holds it lit for HOLD_CYCLES, erases it, then pulses done.
// Optional build macro: TILE_FLASH_OUTLINE_EN draws border pixels in white.
// All outputs are registered. Next-cycle output values are derived from the
// next-state logic, so the outputs line up with the state they describe.
module tile_flash_drawer #(
  parameter int unsigned TILE_SIZE    = 8,
  parameter int unsigned HOLD_CYCLES  = 25000000,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tile_x,
  input  logic [7:0] tile_y,
  input  logic [2:0] tile_colour,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = $clog2(TILE_SIZE);
  localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StHold,
    StErase,
    StDone
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    bx_q, bx_d;
  logic [7:0]    by_q, by_d;
  logic [2:0]    colour_q, colour_d;

  logic [7:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] draw_colour;

  // Next-state logic: sequencing, scan counters and hold down-counter.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    bx_d     = bx_q;
    by_d     = by_q;
    colour_d = colour_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bx_d     = tile_x;
          by_d     = tile_y;
          colour_d = tile_colour;
          col_d    = '0;
          row_d    = '0;
          state_d  = StDraw;
        end
      end
      StDraw, StErase: begin
        // Counters wrap to 0 after the last pixel, ready for the next scan.
        col_d = col_q + CW'(1);
        if (col_q == LAST) begin
          row_d = row_q + CW'(1);
          if (row_q == LAST) begin
            if (state_q == StDraw) begin
              state_d = StHold;
              hold_d  = HOLD_LOAD;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          state_d = StErase;
          col_d   = '0;
          row_d   = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Colour of the pixel about to be drawn during the DRAW pass.
  always_comb begin
`ifdef TILE_FLASH_OUTLINE_EN
    if ((col_d == '0) || (col_d == LAST) || (row_d == '0) || (row_d == LAST)) begin
      draw_colour = 3'b111;
    end else begin
      draw_colour = colour_d;
    end
`else
    draw_colour = colour_d;
`endif
  end

  // Next output values; pixel fields hold their last value when not plotting.
  always_comb begin
    plot_d       = (state_d == StDraw) || (state_d == StErase);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (plot_d) begin
      vga_x_d      = bx_d + {{(8 - CW){1'b0}}, col_d};
      vga_y_d      = by_d + {{(8 - CW){1'b0}}, row_d};
      vga_colour_d = (state_d == StErase) ? ERASE_COLOUR : draw_colour;
    end
  end

  // State, counters, latched tile and registered outputs; reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      colour_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      colour_q     <= colour_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
